// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and stage index width.
package reset_seq_pkg;

    localparam int STAGE_W = 4;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } state_e;

endpackage : reset_seq_pkg

// File: rtl/seq_down_counter.sv
// Loadable down-counter shared by the release delay and the ack timeout.
// Saturates at zero so a stalled enable never wraps around.
module seq_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             loadIn,
    input  logic [CNT_W-1:0] valueIn,
    input  logic             enIn,
    output logic             zeroOut
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (loadIn) begin
            cnt_d = valueIn;
        end else if (enIn && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zeroOut = (cnt_q == '0);

endmodule : seq_down_counter

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order, each DELAY_CYCLES after the previous ack,
// and re-asserts everything if a domain fails to acknowledge within ACK_TIMEOUT cycles.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int   NUM_STAGES       = 4,
    parameter int   DELAY_CYCLES     = 16,
    parameter int   ACK_TIMEOUT      = 255,
    parameter int   CNT_W            = 8,
    parameter logic RST_OUT_POLARITY = 1'b1
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  swRstIn,
    input  logic [NUM_STAGES-1:0] ackIn,
    output logic [NUM_STAGES-1:0] rstOut,
    output logic [STAGE_W-1:0]    stageOut,
    output logic                  doneOut,
    output logic                  errOut,
    output state_e                dbgStateOut
);

    state_e                  state_q;
    logic [STAGE_W-1:0]      stage_q;
    logic [NUM_STAGES-1:0]   rel_q;
    logic                    done_q;
    logic                    err_q;

    logic                    ack_sel;
    logic [NUM_STAGES-1:0]   stage_onehot;
    logic                    is_last;
    logic                    sw_restart;

    logic                    cnt_load;
    logic                    cnt_en;
    logic [CNT_W-1:0]        cnt_value;
    logic                    cnt_zero;

    // Only the ack of the stage currently awaited is ever looked at.
    always_comb begin
        ack_sel      = 1'b0;
        stage_onehot = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stage_q == STAGE_W'(k)) begin
                ack_sel         = ackIn[k];
                stage_onehot[k] = 1'b1;
            end
        end
    end

    assign is_last    = (stage_q == STAGE_W'(NUM_STAGES - 1));
    assign sw_restart = swRstIn && (state_q != ST_HOLD);

    always_comb begin
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_value = '0;
        if (sw_restart) begin
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(DELAY_CYCLES - 1);
                end
                ST_DELAY: begin
                    if (cnt_zero) begin
                        cnt_load  = 1'b1;
                        cnt_value = CNT_W'(ACK_TIMEOUT - 1);
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_sel && !is_last) begin
                        cnt_load  = 1'b1;
                        cnt_value = CNT_W'(DELAY_CYCLES - 1);
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    cnt_en = 1'b0;
                end
            endcase
        end
    end

    seq_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clkIn   (clkIn),
        .rstIn   (rstIn),
        .loadIn  (cnt_load),
        .valueIn (cnt_value),
        .enIn    (cnt_en),
        .zeroOut (cnt_zero)
    );

    // rstIn outranks the software request; a request seen in HOLD is a no-op.
    always_ff @(posedge clkIn) begin
        if (!rstIn || sw_restart) begin
            state_q <= ST_HOLD;
            stage_q <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_q <= ST_DELAY;
                end
                ST_DELAY: begin
                    if (cnt_zero) begin
                        rel_q   <= rel_q | stage_onehot;
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_sel) begin
                        if (is_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= ST_DELAY;
                        end
                    end else if (cnt_zero) begin
                        err_q   <= 1'b1;
                        rel_q   <= '0;
                        state_q <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign rstOut      = RST_OUT_POLARITY ? ~rel_q : rel_q;
    assign stageOut    = stage_q;
    assign doneOut     = done_q;
    assign errOut      = err_q;
    assign dbgStateOut = state_q;

endmodule : reset_sequencer
